class_score_accumulator: RTL

Streaming multiply-accumulate engine that produces the ten 26-bit class scores consumed by the max-score selector. It accepts one input feature per handshake beat, together with the ten per-class weights for that feature. After exactly NUM_FEAT accepted beats it presents the ten scores on registered outputs `Out_0`..`Out_9` with a one-cycle `out_valid` pulse. The scores then hold stable until the next frame completes, so the selector's comparator tree sees static inputs between frames.

---
 rtl/class_score_accumulator.sv | 135 +++++++++++++
 1 files changed

// File: rtl/class_score_accumulator.sv
// class_score_accumulator
// Streaming multiply-accumulate engine producing ten class scores per frame.
// Each accepted beat carries one unsigned feature and ten unsigned weights.
// After NUM_FEAT accepted beats the ten sums are latched into Out_0..Out_9
// with a one-cycle out_valid pulse. They hold until the next frame completes.
module class_score_accumulator #(
  parameter int NUM_FEAT = 784,
  parameter int FEAT_W   = 8,
  parameter int WGT_W    = 8,
  parameter int SCORE_W  = 26
) (
  input  logic                  clk,
  input  logic                  GlobalReset,
  input  logic                  start,
  input  logic                  feat_valid,
  output logic                  feat_ready,
  input  logic [FEAT_W-1:0]     feat,
  input  logic [10*WGT_W-1:0]   weight,
  output logic [SCORE_W-1:0]    Out_0,
  output logic [SCORE_W-1:0]    Out_1,
  output logic [SCORE_W-1:0]    Out_2,
  output logic [SCORE_W-1:0]    Out_3,
  output logic [SCORE_W-1:0]    Out_4,
  output logic [SCORE_W-1:0]    Out_5,
  output logic [SCORE_W-1:0]    Out_6,
  output logic [SCORE_W-1:0]    Out_7,
  output logic [SCORE_W-1:0]    Out_8,
  output logic [SCORE_W-1:0]    Out_9,
  output logic                  out_valid,
  output logic                  busy
);

  localparam int NUM_CLS = 10;
  localparam int PROD_W  = FEAT_W + WGT_W;
  localparam int CNT_W   = (NUM_FEAT > 1) ? $clog2(NUM_FEAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_FEAT - 1);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_ACCUM = 1'b1;

  logic [0:0]         r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [SCORE_W-1:0] r_acc [NUM_CLS];
  logic [SCORE_W-1:0] r_out [NUM_CLS];
  logic               r_out_valid;

  logic               w_accept;
  logic               w_last;
  logic [PROD_W-1:0]  w_prod [NUM_CLS];
  logic [SCORE_W-1:0] w_sum  [NUM_CLS];

  // Ready only while a frame is open; a start pulse in ACCUM blocks that beat.
  assign busy       = (r_state == ST_ACCUM);
  assign feat_ready = (r_state == ST_ACCUM) && !start;
  assign w_accept   = feat_valid && feat_ready;
  assign w_last     = w_accept && (r_cnt == CNT_LAST);

  // Per-class product (full width) and the running sum it produces; wraps mod 2^SCORE_W.
  always_comb begin
    for (int k = 0; k < NUM_CLS; k++) begin
      w_prod[k] = PROD_W'(feat) * PROD_W'(weight[k*WGT_W +: WGT_W]);
      w_sum[k]  = r_acc[k] + SCORE_W'(w_prod[k]);
    end
  end

  // Frame control: IDLE/ACCUM state and beat counter.
  always_ff @(posedge clk or posedge GlobalReset) begin
    if (GlobalReset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state <= ST_ACCUM;
            r_cnt   <= '0;
          end
        end
        ST_ACCUM: begin
          if (start) begin
            r_cnt <= '0;
          end else if (w_accept) begin
            if (w_last) begin
              r_state <= ST_IDLE;
              r_cnt   <= '0;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  // Accumulators: cleared by any start pulse, advanced on every accepted beat.
  always_ff @(posedge clk or posedge GlobalReset) begin
    if (GlobalReset) begin
      for (int k = 0; k < NUM_CLS; k++) r_acc[k] <= '0;
    end else if (start) begin
      for (int k = 0; k < NUM_CLS; k++) r_acc[k] <= '0;
    end else if (w_accept) begin
      for (int k = 0; k < NUM_CLS; k++) r_acc[k] <= w_sum[k];
    end
  end

  // Output registers: latch the completed sums on the final beat only.
  always_ff @(posedge clk or posedge GlobalReset) begin
    if (GlobalReset) begin
      r_out_valid <= 1'b0;
      for (int k = 0; k < NUM_CLS; k++) r_out[k] <= '0;
    end else begin
      r_out_valid <= w_last;
      if (w_last) begin
        for (int k = 0; k < NUM_CLS; k++) r_out[k] <= w_sum[k];
      end
    end
  end

  assign out_valid = r_out_valid;
  assign Out_0 = r_out[0];
  assign Out_1 = r_out[1];
  assign Out_2 = r_out[2];
  assign Out_3 = r_out[3];
  assign Out_4 = r_out[4];
  assign Out_5 = r_out[5];
  assign Out_6 = r_out[6];
  assign Out_7 = r_out[7];
  assign Out_8 = r_out[8];
  assign Out_9 = r_out[9];

endmodule
